clk_period_meas: RTL and testbench
==================================

CLK_PERIOD_MEAS -- requirements
Module: clk_period_meas

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the width of the period and high-time counters and outputs.
REQ-002 The module SHALL have parameter TIMEOUT, default 16, giving the maximum legal period in clk cycles; legal range 2 to 2^CNT_W-1.
REQ-003 clk  input  1  sole clock; all logic rising-edge triggered.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  measurement enable.
REQ-006 clk_in  input  1  divided clock from the divider stage; already synchronous to clk, so no synchronizer is used.
REQ-007 period  output  CNT_W  clk cycles between the last two rising edges of clk_in.
REQ-008 high_time  output  CNT_W  clk cycles clk_in was high within that period.
REQ-009 meas_valid  output  1  one-cycle pulse; period and high_time were updated this cycle.
REQ-010 stuck  output  1  level; no rising edge seen within TIMEOUT cycles.

Function
REQ-011 The module SHALL register clk_in into clk_in_d each cycle; rise = clk_in & ~clk_in_d.
REQ-012 The FSM SHALL have three states: IDLE (no reference edge yet), MEAS (reference edge held, counting) and STUCK (timed out).
REQ-013 per_cnt SHALL be loaded with 1 on a rise cycle, SHALL increment on other cycles in IDLE or MEAS while en=1, SHALL hold in STUCK, and SHALL clear to 0 when en=0.
REQ-014 hi_cnt SHALL be loaded with 1 on a rise cycle and SHALL otherwise add clk_in each cycle in MEAS.
REQ-015 A rise in MEAS SHALL set period<=per_cnt, high_time<=hi_cnt and meas_valid<=1, all registered, so they are visible in the cycle after the rise cycle.
REQ-016 A rise in IDLE or STUCK SHALL move the FSM to MEAS without asserting meas_valid, because no full period has been observed.
REQ-017 In IDLE or MEAS, if per_cnt==TIMEOUT and there is no rise, the FSM SHALL move to STUCK and stuck SHALL be 1 from the next cycle.
REQ-018 A rise in the same cycle that per_cnt==TIMEOUT SHALL win: a valid measurement with period=TIMEOUT is produced and stuck stays 0.
REQ-019 stuck SHALL clear in the cycle after the rise that leaves STUCK.
REQ-020 en=0 SHALL force the FSM to IDLE on the next cycle, SHALL clear stuck and meas_valid, and SHALL leave period and high_time holding their values.
REQ-021 meas_valid SHALL never be high for two consecutive cycles, because the minimum legal period is 2.
REQ-022 No counter SHALL exceed TIMEOUT, so no wrap-around is possible.

Reset
REQ-023 rst=1 SHALL, on the next clk edge, set state=IDLE, per_cnt=0, hi_cnt=0, period=0, high_time=0, meas_valid=0 and stuck=0.
REQ-024 Reset SHALL set clk_in_d=1, so that clk_in being high at reset release is not detected as a rise.
REQ-025 rst SHALL override en and clk_in, including when asserted mid-period; no meas_valid SHALL be issued for the interrupted period.

Verification
REQ-026 Reset, en=1, clk_in repeating 1,0,0,0 -> no valid on the first rise; then meas_valid once every 4 cycles, one cycle after each rise, with period=4 and high_time=1.
REQ-027 clk_in repeating 1,1,1,0,0,0,0 -> period=7, high_time=3 on every valid after the first.
REQ-028 TIMEOUT=16, steady period-4 stream, then clk_in held 0 -> stuck rises 17 cycles after the last rise and no valid is issued; stream resumes -> stuck clears one cycle after the first rise, no valid on that rise, valid with period=4 on the next rise.
REQ-029 Period exactly 16 -> meas_valid with period=16 and stuck=0; period 17 -> stuck=1 and no valid for that period.
REQ-030 clk_in=1 while rst deasserts -> no valid; en dropped mid-period for 3 cycles -> IDLE, outputs held, and the first rise after re-enable gives no valid.
REQ-031 rst asserted two cycles before an expected rise -> all outputs 0 the following cycle, and no valid at that rise.

Source files
------------

// File: rtl/clk_period_meas.sv
// Measures period and high time of a slow, clk-synchronous clock (clk_in) in clk cycles,
// and flags a stuck input when no rising edge arrives within TIMEOUT cycles.
module clk_period_meas #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } state_e;

    state_e           state_q,      state_d;
    logic [CNT_W-1:0] per_cnt_q,    per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q,     hi_cnt_d;
    logic [CNT_W-1:0] period_q,     period_d;
    logic [CNT_W-1:0] high_time_q,  high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             stuck_q,      stuck_d;
    logic             clk_in_d_q;

    logic             rise_c;
    logic             at_limit_c;

    assign rise_c     = clk_in & ~clk_in_d_q;
    assign at_limit_c = (per_cnt_q == TIMEOUT_C);

    // Next-state, counter and output logic; a rise always wins over the timeout.
    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;

        if (!en) begin
            state_d   = IDLE;
            per_cnt_d = ZERO_C;
            hi_cnt_d  = ZERO_C;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise_c) begin
                        state_d   = MEAS;
                        per_cnt_d = ONE_C;
                        hi_cnt_d  = ONE_C;
                    end else if (at_limit_c) begin
                        state_d = STUCK;
                    end else begin
                        per_cnt_d = per_cnt_q + ONE_C;
                    end
                end
                MEAS: begin
                    if (rise_c) begin
                        period_d     = per_cnt_q;
                        high_time_d  = hi_cnt_q;
                        meas_valid_d = 1'b1;
                        per_cnt_d    = ONE_C;
                        hi_cnt_d     = ONE_C;
                    end else if (at_limit_c) begin
                        state_d = STUCK;
                    end else begin
                        per_cnt_d = per_cnt_q + ONE_C;
                        hi_cnt_d  = hi_cnt_q + CNT_W'(clk_in);
                    end
                end
                STUCK: begin
                    if (rise_c) begin
                        state_d   = MEAS;
                        per_cnt_d = ONE_C;
                        hi_cnt_d  = ONE_C;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    per_cnt_d = ZERO_C;
                    hi_cnt_d  = ZERO_C;
                end
            endcase
        end

        stuck_d = (state_d == STUCK);
    end

    // Edge-detect register resets high so a level already high at release is not a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            per_cnt_q    <= ZERO_C;
            hi_cnt_q     <= ZERO_C;
            period_q     <= ZERO_C;
            high_time_q  <= ZERO_C;
            meas_valid_q <= 1'b0;
            stuck_q      <= 1'b0;
            clk_in_d_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            stuck_q      <= stuck_d;
            clk_in_d_q   <= clk_in;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_period_meas.sv
// Scoreboard bench for clk_period_meas: a timestamp-based reference model predicts
// every output cycle; a negedge monitor pops and compares.
module tb_clk_period_meas;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 16;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             en     = 1'b0;
    logic             clk_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             stuck;

    clk_period_meas #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clk_in    (clk_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit valid;
        int per;
        int hi;
        bit stk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model: rises are timestamps; a period is the distance between two of them
    bit hist[int];
    bit m_prev;
    bit m_have_ref;
    bit m_stuck;
    int m_last;
    int m_zero;
    int m_per;
    int m_hi;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic model(input int c, input bit r, input bit e, input bit ci);
        bit   rise;
        bit   vld;
        int   elapsed;
        exp_t x;
        vld = 1'b0;
        if (r) begin
            m_have_ref = 1'b0;
            m_stuck    = 1'b0;
            m_zero     = c;
            m_prev     = 1'b1;
            m_per      = 0;
            m_hi       = 0;
        end else begin
            rise    = ci && !m_prev;
            m_prev  = ci;
            hist[c] = ci;
            if (!e) begin
                m_have_ref = 1'b0;
                m_stuck    = 1'b0;
                m_zero     = c;
            end else if (rise) begin
                if (m_have_ref && !m_stuck) begin
                    vld   = 1'b1;
                    m_per = c - m_last;
                    m_hi  = 0;
                    for (int k = m_last; k < c; k++) m_hi += int'(hist[k]);
                end
                m_have_ref = 1'b1;
                m_stuck    = 1'b0;
                m_last     = c;
            end else if (!m_stuck) begin
                elapsed = m_have_ref ? (c - m_last) : (c - m_zero - 1);
                if (elapsed == int'(TIMEOUT)) begin
                    m_stuck    = 1'b1;
                    m_have_ref = 1'b0;
                end
            end
        end
        x.cyc   = c + 1;
        x.valid = vld;
        x.per   = m_per;
        x.hi    = m_hi;
        x.stk   = m_stuck;
        sb.push_back(x);
    endtask

    task automatic step(input bit r, input bit e, input bit ci);
        rst    = r;
        en     = e;
        clk_in = ci;
        model(cyc, r, e, ci);
        @(posedge clk);
        #1;
    endtask

    task automatic pat(input int h, input int p);
        for (int i = 0; i < p; i++) step(1'b0, 1'b1, i < h);
    endtask

    // Monitor: compare every predicted cycle once the DUT has reached it.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc) chk("stale_entry", mon_e.cyc, cyc);
            chk("meas_valid", int'(meas_valid), int'(mon_e.valid));
            chk("stuck",      int'(stuck),      int'(mon_e.stk));
            chk("period",     int'(period),     mon_e.per);
            chk("high_time",  int'(high_time),  mon_e.hi);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int p;
        int h;
        int n;
        @(posedge clk);
        #1;
        // Reset with clk_in high, then release while high: no rise
        repeat (2) step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        repeat (8) pat(1, 4);
        repeat (5) pat(3, 7);
        // Stream, timeout, resume
        repeat (4) pat(1, 4);
        repeat (25) step(1'b0, 1'b1, 1'b0);
        repeat (4) pat(1, 4);
        // Boundary periods 16 and 17
        pat(1, 16);
        pat(1, 16);
        pat(1, 17);
        repeat (3) pat(1, 4);
        // Enable dropped mid-period for 3 cycles
        repeat (2) pat(2, 6);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) pat(2, 6);
        // Reset two cycles before an expected rise
        pat(1, 5);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) pat(1, 5);
        // Randomized mix
        repeat (400) begin
            kind = int'($urandom_range(0, 29));
            if (kind == 0) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (kind <= 2) begin
                n = int'($urandom_range(1, 4));
                repeat (n) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                p = int'($urandom_range(2, 20));
                h = int'($urandom_range(1, p - 1));
                pat(h, p);
            end
        end
        repeat (3) step(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
